// File: rtl/dft64_pkg.sv
// Shared types and default geometry for the dft64 front-end controller.
// Imported by dft64_beat_packer and dft64_ctrl.
package dft64_pkg;

  localparam int SAMPLE_W_DEF     = 16;
  localparam int BEAT_SAMPLES_DEF = 8;
  localparam int FRAME_BEATS_DEF  = 8;

  typedef logic [SAMPLE_W_DEF*BEAT_SAMPLES_DEF-1:0] beat_t;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    FILL    = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    RECOVER = 3'd4
  } dft64_state_e;

endpackage

// File: rtl/dft64_beat_packer.sv
// Shift register that gathers BEAT_SAMPLES serial samples into one packed beat.
// The first sample accepted ends up in the most significant slot.
module dft64_beat_packer
  import dft64_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int BEAT_SAMPLES = BEAT_SAMPLES_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 accept,
  input  logic [SAMPLE_W-1:0]                  s_data,
  output logic [SAMPLE_W*BEAT_SAMPLES-1:0]     beat,
  output logic                                 beat_ready,
  output logic [$clog2(BEAT_SAMPLES)-1:0]      samp_cnt
);

  localparam int BW  = SAMPLE_W * BEAT_SAMPLES;
  localparam int SW  = BW - SAMPLE_W;
  localparam int SCW = $clog2(BEAT_SAMPLES);

  // Only the older samples are stored; the final sample of a beat goes
  // straight from s_data into the beat output.
  logic [SW-1:0]  shift_q, shift_d;
  logic [SCW-1:0] samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]  packed_beat;

  assign packed_beat = {shift_q, s_data};
  assign beat        = packed_beat;
  assign samp_cnt    = samp_cnt_q;

  always_comb begin
    shift_d    = shift_q;
    samp_cnt_d = samp_cnt_q;
    beat_ready = 1'b0;
    if (clr) begin
      shift_d    = '0;
      samp_cnt_d = '0;
    end else if (accept) begin
      shift_d = packed_beat[SW-1:0];
      if (samp_cnt_q == SCW'(BEAT_SAMPLES - 1)) begin
        samp_cnt_d = '0;
        beat_ready = 1'b1;
      end else begin
        samp_cnt_d = samp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      samp_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      samp_cnt_q <= samp_cnt_d;
    end
  end

endmodule

// File: rtl/dft64_ctrl.sv
// Frame scheduler for dft64: packs samples into beats, issues one frame, waits
// for dft_done under a timeout. Define DFT64_CTRL_STATS_EN for frame/timeout counters.
module dft64_ctrl
  import dft64_pkg::*;
#(
  parameter int SAMPLE_W        = SAMPLE_W_DEF,
  parameter int BEAT_SAMPLES    = BEAT_SAMPLES_DEF,
  parameter int FRAME_BEATS     = FRAME_BEATS_DEF,
  parameter int TIMEOUT         = 6,
  parameter int INIT_RST_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              sreset,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [SAMPLE_W-1:0]               s_data,
  output logic [SAMPLE_W*BEAT_SAMPLES-1:0]  dft_samples,
  output logic                              dft_rel,
  output logic                              dft_sreset,
  input  logic                              dft_done,
  output logic                              frame_done,
  output logic                              frame_err,
  output logic                              err_sticky,
  input  logic                              err_clr,
  output logic                              busy,
  output dft64_state_e                      dbg_state
`ifdef DFT64_CTRL_STATS_EN
  ,
  output logic [15:0]                       frame_count,
  output logic [7:0]                        timeout_count
`endif
);

  localparam int BW  = SAMPLE_W * BEAT_SAMPLES;
  localparam int SCW = $clog2(BEAT_SAMPLES);
  localparam int BCW = $clog2(FRAME_BEATS + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int ICW = $clog2(INIT_RST_CYCLES + 1);

  // Handshake: a sample transfers on every rising clk edge where s_valid and
  // s_ready are both high; s_ready is registered and never looks at s_valid.
  dft64_state_e   state_q, state_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0]  samples_q, samples_d;
  logic           s_ready_q, s_ready_d;
  logic           rel_q, rel_d;
  logic           dft_sreset_q, dft_sreset_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_err_q, frame_err_d;
  logic           err_sticky_q, err_sticky_d;
  logic           timeout_hit;
  logic           pk_clr;
  logic           accept;
  logic [BW-1:0]  pk_beat;
  logic           pk_beat_ready;
  logic [SCW-1:0] pk_samp_cnt;

  assign accept = s_valid & s_ready_q;

  dft64_beat_packer #(
    .SAMPLE_W     (SAMPLE_W),
    .BEAT_SAMPLES (BEAT_SAMPLES)
  ) u_packer (
    .clk        (clk),
    .rst        (sreset),
    .clr        (pk_clr),
    .accept     (accept),
    .s_data     (s_data),
    .beat       (pk_beat),
    .beat_ready (pk_beat_ready),
    .samp_cnt   (pk_samp_cnt)
  );

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    samples_d    = samples_q;
    s_ready_d    = s_ready_q;
    rel_d        = 1'b0;
    dft_sreset_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    timeout_hit  = 1'b0;
    pk_clr       = 1'b0;
    case (state_q)
      INIT: begin
        dft_sreset_d = 1'b1;
        if (init_cnt_q == ICW'(INIT_RST_CYCLES - 1)) begin
          state_d      = FILL;
          init_cnt_d   = '0;
          dft_sreset_d = 1'b0;
          s_ready_d    = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      FILL: begin
        if (pk_beat_ready) begin
          samples_d  = pk_beat;
          rel_d      = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Closing the frame: drop s_ready so no sample beyond the frame lands.
          if (beat_cnt_q == BCW'(FRAME_BEATS - 1)) begin
            s_ready_d = 1'b0;
          end
        end
        // beat_cnt reaches FRAME_BEATS only during the last beat's issue cycle.
        if (beat_cnt_q == BCW'(FRAME_BEATS)) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (dft_done) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          state_d      = RECOVER;
          frame_err_d  = 1'b1;
          dft_sreset_d = 1'b1;
          timeout_hit  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DONE, RECOVER: begin
        state_d    = FILL;
        s_ready_d  = 1'b1;
        beat_cnt_d = '0;
        wait_cnt_d = '0;
        pk_clr     = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
    // A timeout in the same cycle as err_clr keeps the error visible.
    if (timeout_hit) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      samples_q    <= '0;
      s_ready_q    <= 1'b0;
      rel_q        <= 1'b0;
      dft_sreset_q <= 1'b1;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      samples_q    <= samples_d;
      s_ready_q    <= s_ready_d;
      rel_q        <= rel_d;
      dft_sreset_q <= dft_sreset_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign dft_samples = samples_q;
  assign dft_rel     = rel_q;
  assign dft_sreset  = dft_sreset_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_sticky  = err_sticky_q;
  assign dbg_state   = state_q;
  assign busy        = !((state_q == FILL) && (beat_cnt_q == '0) && (pk_samp_cnt == '0));

`ifdef DFT64_CTRL_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  timeout_count_q, timeout_count_d;

  always_comb begin
    frame_count_d   = frame_count_q;
    timeout_count_d = timeout_count_q;
    if (frame_done_d) begin
      frame_count_d = frame_count_q + 1'b1;
    end
    // Timeouts saturate so a stuck dft64 never reads back as healthy.
    if (frame_err_d && (timeout_count_q != 8'hFF)) begin
      timeout_count_d = timeout_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      frame_count_q   <= '0;
      timeout_count_q <= '0;
    end else begin
      frame_count_q   <= frame_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign frame_count   = frame_count_q;
  assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_dft64_ctrl.sv
// Self-checking bench for dft64_ctrl: table of frame/WAIT scenarios plus
// hand-written reset and mid-frame reset sequences.
module tb_dft64_ctrl;
  import dft64_pkg::*;

  localparam int TIMEOUT = 6;
  localparam logic [127:0] SINE_BEAT0 =
    128'h0000_0021_0042_0062_0080_009C_00B5_00CB;

  logic         clk = 1'b0;
  logic         sreset = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [15:0]  s_data = '0;
  beat_t        dft_samples;
  logic         dft_rel;
  logic         dft_sreset;
  logic         dft_done = 1'b0;
  logic         frame_done;
  logic         frame_err;
  logic         err_sticky;
  logic         err_clr = 1'b0;
  logic         busy;
  dft64_state_e dbg_state;
`ifdef DFT64_CTRL_STATS_EN
  logic [15:0]  frame_count;
  logic [7:0]   timeout_count;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dft64_ctrl #(
    .SAMPLE_W(16), .BEAT_SAMPLES(8), .FRAME_BEATS(8),
    .TIMEOUT(TIMEOUT), .INIT_RST_CYCLES(2)
  ) dut (
    .clk(clk), .sreset(sreset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .dft_samples(dft_samples), .dft_rel(dft_rel),
    .dft_sreset(dft_sreset), .dft_done(dft_done), .frame_done(frame_done),
    .frame_err(frame_err), .err_sticky(err_sticky), .err_clr(err_clr),
    .busy(busy), .dbg_state(dbg_state)
`ifdef DFT64_CTRL_STATS_EN
    , .frame_count(frame_count), .timeout_count(timeout_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  beat_t        got_beats[$];
  int           rel_cyc[$];
  int           cyc = 0;
  logic [127:0] last_beat = '0;
  logic [127:0] mon_e;
  int           n_fdone = 0;
  int           n_ferr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!sreset) begin
      if (dft_rel) begin
        rel_cyc.push_back(cyc);
        got_beats.push_back(dft_samples);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected act=%0h exp=none", dft_samples);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", dft_samples, mon_e);
          last_beat = mon_e;
        end
      end else begin
        check("beat_hold", dft_samples, last_beat);
      end
      if (frame_done) n_fdone++;
      if (frame_err)  n_ferr++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] sine_s(input int k);
    real x;
    x = 256.0 * $sin(2.0 * 3.14159265358979 * k / 48.0);
    return 16'($rtoi($floor(x + 0.5)));
  endfunction

  task automatic send_samples(input int n, input bit gaps);
    logic [127:0] pack;
    logic [15:0]  d;
    int           sent;
    int           budget;
    bit           v;
    pack   = '0;
    sent   = 0;
    budget = 0;
    while (sent < n && budget < 4000) begin
      v        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d        = gaps ? 16'($urandom_range(0, 65535)) : sine_s(sent);
      s_valid  = v;
      s_data   = d;
      dft_done = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && s_ready) begin
        pack = {pack[111:0], d};
        sent++;
        if (sent % 8 == 0) exp_q.push_back(pack);
      end
      @(negedge clk);
      budget++;
    end
    s_valid  = 1'b0;
    dft_done = 1'b0;
    if (sent < n) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=%0d exp=%0d", sent, n);
    end
  endtask

  task automatic wait_state(input dft64_state_e target, input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, dbg_state, target);
  endtask

  typedef struct {
    int done_idx;     // WAIT cycle index carrying dft_done, -1 for never
    bit pre_clr;      // pulse err_clr before the frame
    bit clr_at_term;  // err_clr on the terminal WAIT cycle
    bit gaps;         // random s_valid gaps and stray dft_done in FILL
    bit exp_done;
    bit exp_err;
    bit exp_sticky;
    int exp_res;      // cycles spent in WAIT
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int k;
    if (v.pre_clr) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_clr", err_sticky, 1'b0);
    end
    got_beats.delete();
    rel_cyc.delete();
    check("idle_busy", busy, 1'b0);
    send_samples(64, v.gaps);
    check("s_ready_after_last", s_ready, 1'b0);
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    wait_state(WAIT, 4, "enter_wait");
    k = 0;
    while (dbg_state == WAIT && k < 20) begin
      check("wait_outputs", {s_ready, dft_rel, frame_done, frame_err}, 4'b0000);
      dft_done = (k == v.done_idx);
      err_clr  = v.clr_at_term && (k == TIMEOUT - 1);
      @(negedge clk);
      k++;
    end
    dft_done = 1'b0;
    err_clr  = 1'b0;
    check("wait_residency", k, v.exp_res);
    check("end_state", dbg_state, v.exp_err ? RECOVER : DONE);
    check("frame_done", frame_done, v.exp_done);
    check("frame_err", frame_err, v.exp_err);
    check("dft_sreset_pulse", dft_sreset, v.exp_err);
    check("err_sticky", err_sticky, v.exp_sticky);
    @(negedge clk);
    s_valid = 1'b0;
    check("back_to_fill", {dbg_state, s_ready, busy, frame_done, frame_err, dft_sreset},
          {FILL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("beats_issued", got_beats.size(), 8);
    check("exp_q_drained", exp_q.size(), 0);
    if (!v.gaps && got_beats.size() == 8) begin
      check("first_beat", got_beats[0], SINE_BEAT0);
      for (int i = 1; i < 8; i++) check("rel_spacing", rel_cyc[i] - rel_cyc[i-1], 8);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_fdone;
    int exp_ferr;
    vecs[0] = '{done_idx: 2, pre_clr: 0, clr_at_term: 0, gaps: 0,
                exp_done: 1, exp_err: 0, exp_sticky: 0, exp_res: 3};
    vecs[1] = '{done_idx: 0, pre_clr: 0, clr_at_term: 0, gaps: 1,
                exp_done: 1, exp_err: 0, exp_sticky: 0, exp_res: 1};
    vecs[2] = '{done_idx: 5, pre_clr: 0, clr_at_term: 0, gaps: 0,
                exp_done: 1, exp_err: 0, exp_sticky: 0, exp_res: 6};
    vecs[3] = '{done_idx: -1, pre_clr: 0, clr_at_term: 0, gaps: 1,
                exp_done: 0, exp_err: 1, exp_sticky: 1, exp_res: 6};
    vecs[4] = '{done_idx: -1, pre_clr: 1, clr_at_term: 1, gaps: 0,
                exp_done: 0, exp_err: 1, exp_sticky: 1, exp_res: 6};
    vecs[5] = '{done_idx: 1, pre_clr: 1, clr_at_term: 0, gaps: 1,
                exp_done: 1, exp_err: 0, exp_sticky: 0, exp_res: 2};
    vecs[6] = '{done_idx: -1, pre_clr: 0, clr_at_term: 0, gaps: 1,
                exp_done: 0, exp_err: 1, exp_sticky: 1, exp_res: 6};

    // Reset held with s_valid high.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, INIT);
    check("rst_outputs", {s_ready, dft_rel, frame_done, frame_err, err_sticky, dft_sreset, busy},
          7'b0000011);
    check("rst_samples", dft_samples, 128'h0);
`ifdef DFT64_CTRL_STATS_EN
    check("rst_stats", {frame_count, timeout_count}, 24'h0);
`endif
    sreset = 1'b0;
    @(negedge clk);
    check("init_c1", {dbg_state, dft_sreset, s_ready}, {INIT, 1'b1, 1'b0});
    @(negedge clk);
    check("init_c2", {dbg_state, dft_sreset, s_ready, err_sticky}, {FILL, 1'b0, 1'b1, 1'b0});
    s_valid = 1'b0;

    exp_fdone = 0;
    exp_ferr  = 0;
    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      exp_fdone += int'(vecs[i].exp_done);
      exp_ferr  += int'(vecs[i].exp_err);
    end
`ifdef DFT64_CTRL_STATS_EN
    check("stats_frames", frame_count, 16'(exp_fdone));
    check("stats_timeouts", timeout_count, 8'(exp_ferr));
`endif

    // Mid-frame reset after 20 samples: async clear, fresh restart.
    send_samples(20, 1'b0);
    #2;
    sreset    = 1'b1;
    last_beat = '0;
    exp_q.delete();
    #1;
    check("async_rst", {dft_sreset, s_ready, dft_rel, busy, err_sticky}, 5'b10010);
    check("async_rst_samples", dft_samples, 128'h0);
    @(negedge clk);
    check("rst_state_mid", dbg_state, INIT);
    sreset = 1'b0;
    wait_state(FILL, 5, "reinit_fill");
`ifdef DFT64_CTRL_STATS_EN
    check("stats_cleared", {frame_count, timeout_count}, 24'h0);
`endif
    run_vec(vecs[0]);
    exp_fdone++;
    repeat (3) @(negedge clk);

    check("total_frame_done", n_fdone, exp_fdone);
    check("total_frame_err", n_ferr, exp_ferr);
    check("exp_q_final", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=%0d exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dft64_ctrl.md
Name: dft64_ctrl

Overview:
- Frame scheduler in front of dft64: accepts a serial 16-bit sample stream (valid/ready) and packs it into 8-sample beats.
- Issues 8 beats per 64-point frame using dft64's samples/rel interface, then waits for done under a cycle timeout.
- On timeout, resets dft64 via its sreset and flags an error.
- Sits between the audio sample source and dft64; reports frame completion and errors to the system.

Parameters:
- SAMPLE_W, 16, sample width in bits
- BEAT_SAMPLES, 8, samples packed per beat
- FRAME_BEATS, 8, beats per frame (64 samples)
- TIMEOUT, 6, max cycles in WAIT for dft_done, must be >= 1
- INIT_RST_CYCLES, 2, cycles dft_sreset is held after controller reset release

Ports:
- clk  in  1  clock
- sreset  in  1  asynchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_data  in  SAMPLE_W  input sample, two's complement
- dft_samples  out  SAMPLE_W*BEAT_SAMPLES  packed beat; first-accepted sample in MSBs [127:112], last in [15:0]
- dft_rel  out  1  beat-valid strobe; dft64 consumes dft_samples on every clk edge with dft_rel=1
- dft_sreset  out  1  synchronous reset to dft64
- dft_done  in  1  dft64 result-ready
- frame_done  out  1  one-cycle pulse, frame completed
- frame_err  out  1  one-cycle pulse, timeout occurred
- err_sticky  out  1  set on timeout, held until cleared
- err_clr  in  1  clears err_sticky
- busy  out  1  high in every state except FILL with beat_cnt=0 and samp_cnt=0

Behaviour:
- Reset values:
  - State = INIT; s_ready, dft_rel, frame_done, frame_err, err_sticky = 0.
  - dft_sreset = 1; dft_samples = 0; samp_cnt, beat_cnt, wait_cnt = 0; busy = 1.
- INIT: dft_sreset=1, s_ready=0 for INIT_RST_CYCLES cycles after reset deassertion, then go to FILL. dft_sreset is 0 in FILL.
- FILL:
  - s_ready=1. A sample is accepted on a cycle with s_valid & s_ready; it shifts into the pack register and increments samp_cnt.
  - When the BEAT_SAMPLES-th sample is accepted, the packed beat is loaded into dft_samples and dft_rel=1 on the next cycle for exactly one cycle (registered output, 1-cycle latency).
  - beat_cnt increments on each issued beat. Acceptance continues while the beat issues, with no bubble. dft_samples holds its value between beats.
  - After the issue cycle of beat FRAME_BEATS-1, go to WAIT, clear wait_cnt, s_ready=0.
  - s_ready is 0 in the same cycle the last sample of a frame is accepted +1 onward; no 65th sample is accepted.
- WAIT:
  - s_ready=0, dft_rel=0.
  - dft_done=1 → DONE.
  - Otherwise, if wait_cnt==TIMEOUT-1 → RECOVER; else wait_cnt++.
  - Residency in WAIT is at most TIMEOUT cycles.
  - If dft_done=1 on the terminal-count cycle, done wins.
- DONE: frame_done=1 for one cycle; clear counters; → FILL.
- RECOVER: dft_sreset=1 and frame_err=1 for one cycle; err_sticky←1; clear counters; → FILL.
- err_clr: err_sticky←0 unless set in the same cycle (set wins).
- dft_done outside WAIT is ignored: no pulse, no state change.
- Asserting sreset mid-frame discards partial beats and counters, drives dft_sreset=1 immediately (async), and restarts in INIT.
- Arithmetic: counters are $clog2-sized; no arithmetic on sample data; samples are passed bit-exact.

Optional Feature:
- Macro DFT64_CTRL_STATS_EN.
- Defined: adds outputs frame_count[15:0] (increments on frame_done, wraps 0xFFFF→0) and timeout_count[7:0] (increments on frame_err, saturates at 0xFF). Both reset to 0 and are cleared only by sreset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dft64_pkg holds:
  - the state enum typedef (INIT, FILL, WAIT, DONE, RECOVER);
  - SAMPLE_W, BEAT_SAMPLES and FRAME_BEATS defaults;
  - the beat typedef logic [SAMPLE_W*BEAT_SAMPLES-1:0].
- One natural sub-module: dft64_beat_packer, a shift register plus samp_cnt that emits the beat and a beat-ready strobe. FSM, timeout and status live in dft64_ctrl.

Test Plan:
- Reset release with s_valid=1 → dft_sreset=1 for 2 cycles, s_ready=0 until the first FILL cycle, err_sticky=0.
- Stream 64 samples of a 1 kHz sine at 48 kHz scaled by 2^8, s_valid held high → exactly 8 dft_rel pulses spaced 8 cycles apart. First beat = {s0..s7} with s0 in bits [127:112]; s_ready=0 after sample 63.
- dft_done asserted on the 3rd WAIT cycle → frame_done pulse the next cycle, no frame_err, next frame accepted immediately.
- dft_done never asserted → after 6 WAIT cycles, frame_err and dft_sreset pulse together, err_sticky=1. err_clr then clears it. A simultaneous err_clr and timeout leaves err_sticky=1.
- Random s_valid gaps (~50% duty) → beats are bit-exact with the packed input order, and no sample is lost or duplicated over 4 frames.
- sreset asserted after 20 samples → outputs return to reset values asynchronously. The next frame starts from sample 0 and no stale beat is issued. With DFT64_CTRL_STATS_EN, counters read 0.
